// File: rtl/qsys_test_gpi_pkg.sv
// qsys_test_gpi_pkg: shared constants and types for the GPI Avalon slave.
//   ADDR_*        word addresses of the four registers
//   EDGE_SEL_RST  reset value of EDGE_SEL (capture rising edges everywhere)
//   rd_state_t    Avalon read handshake states
//   cnt_width()   prescaler counter width, at least one bit
package qsys_test_gpi_pkg;
   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_EDGE     = 2'd1;
   localparam logic [1:0] ADDR_MASK     = 2'd2;
   localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;
   localparam logic [31:0] EDGE_SEL_RST = 32'hFFFF_FFFF;
   typedef enum logic {S_IDLE, S_ACK} rd_state_t;
   function automatic int cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction
endpackage

// File: rtl/qsys_test_gpi_debounce.sv
// qsys_test_gpi_debounce: synchronise and debounce the GPI pins.
//   clk, rst_n     clock, asynchronous active-low reset
//   i_pins         asynchronous pin inputs
//   o_deb          debounced pin value
//   o_deb_changed  bits of o_deb that change at the coming clock edge
module qsys_test_gpi_debounce
   import qsys_test_gpi_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEBOUNCE_DIV = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_pins,
   output logic [WIDTH-1:0] o_deb,
   output logic [WIDTH-1:0] o_deb_changed
);
   localparam int CW = cnt_width(DEBOUNCE_DIV);
   logic [WIDTH-1:0] r_meta, r_sync, r_samp, r_deb;
   logic [CW-1:0]    r_cnt;
   logic             r_primed;
   logic             w_tick;
   logic [WIDTH-1:0] w_stable;
   assign w_tick   = r_cnt == CW'(DEBOUNCE_DIV - 1);
   assign w_stable = ~(r_sync ^ r_samp);
   // Combinational so the owner can latch edges on the same edge deb updates;
   // the priming tick never reports a change.
   assign o_deb_changed = (w_tick && r_primed) ? (w_stable & (r_sync ^ r_deb)) : '0;
   assign o_deb = r_deb;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta   <= '0;
         r_sync   <= '0;
         r_samp   <= '0;
         r_deb    <= '0;
         r_cnt    <= '0;
         r_primed <= 1'b0;
      end else begin
         r_meta <= i_pins;
         r_sync <= r_meta;
         r_cnt  <= w_tick ? '0 : r_cnt + CW'(1);
         if (w_tick) begin
            r_samp   <= r_sync;
            r_primed <= 1'b1;
            r_deb    <= r_primed ? (r_deb ^ o_deb_changed) : r_sync;
         end
      end
   end
endmodule

// File: rtl/qsys_test_gpi.sv
// qsys_test_gpi: Avalon-MM slave returning debounced GPI pins with edge interrupts.
//   csi_MCLK_clk, rsi_MRST_reset_n  clock, asynchronous active-low reset
//   avs_GPI_*                       Avalon-MM slave (2-cycle reads, 1-cycle writes)
//   ins_GPI_irq                     level interrupt, |(EDGE & MASK)
//   coe_GPI                         asynchronous pin inputs
module qsys_test_gpi
   import qsys_test_gpi_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEBOUNCE_DIV = 1000
) (
   input  logic             csi_MCLK_clk,
   input  logic             rsi_MRST_reset_n,
   input  logic [1:0]       avs_GPI_address,
   input  logic             avs_GPI_read,
   output logic [31:0]      avs_GPI_readdata,
   input  logic             avs_GPI_write,
   input  logic [31:0]      avs_GPI_writedata,
   output logic             avs_GPI_waitrequest,
   output logic             ins_GPI_irq,
   input  logic [WIDTH-1:0] coe_GPI
);
   rd_state_t        r_state;
   logic             r_rst_wait;
   logic [31:0]      r_rdata;
   logic [WIDTH-1:0] r_edge, r_mask, r_sel;
   logic [WIDTH-1:0] w_deb, w_chg, w_set, w_clr, w_wdata;
   logic [31:0]      w_rsel;
   qsys_test_gpi_debounce #(.WIDTH(WIDTH), .DEBOUNCE_DIV(DEBOUNCE_DIV)) u_deb (
      .clk           (csi_MCLK_clk),
      .rst_n         (rsi_MRST_reset_n),
      .i_pins        (coe_GPI),
      .o_deb         (w_deb),
      .o_deb_changed (w_chg)
   );
   assign w_wdata = avs_GPI_writedata[WIDTH-1:0];
   // A changing bit rises when it is currently 0, falls when currently 1.
   assign w_set = w_chg & (r_sel ^ w_deb);
   assign w_clr = (avs_GPI_write && avs_GPI_address == ADDR_EDGE) ? w_wdata : '0;
   assign w_rsel = (avs_GPI_address == ADDR_DATA) ? 32'(w_deb)  :
                   (avs_GPI_address == ADDR_EDGE) ? 32'(r_edge) :
                   (avs_GPI_address == ADDR_MASK) ? 32'(r_mask) : 32'(r_sel);
   // Held high through reset and its first clock; a new read stalls one cycle.
   assign avs_GPI_waitrequest = r_rst_wait | (r_state == S_IDLE && avs_GPI_read);
   assign avs_GPI_readdata    = r_rdata;
   assign ins_GPI_irq         = |(r_edge & r_mask);
   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n) begin
         r_state    <= S_IDLE;
         r_rst_wait <= 1'b1;
         r_rdata    <= '0;
         r_edge     <= '0;
         r_mask     <= '0;
         r_sel      <= EDGE_SEL_RST[WIDTH-1:0];
      end else begin
         r_rst_wait <= 1'b0;
         r_edge     <= (r_edge & ~w_clr) | w_set;
         if (avs_GPI_write && avs_GPI_address == ADDR_MASK) r_mask <= w_wdata;
         if (avs_GPI_write && avs_GPI_address == ADDR_EDGE_SEL) r_sel <= w_wdata;
         if (r_state == S_IDLE && avs_GPI_read) begin
            r_rdata <= w_rsel;
            r_state <= S_ACK;
         end else begin
            r_state <= S_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_qsys_test_gpi.sv
// tb_qsys_test_gpi: directed bench; u_d1 is WIDTH=16/DIV=1, u_d4 is WIDTH=32/DIV=4.
module tb_qsys_test_gpi;
   import qsys_test_gpi_pkg::*;
   logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [1:0]  addr = '0;
   logic [31:0] wdata = '0, rd1, rd4, rdata;
   logic        w1, w4, wt, q1, q4;
   logic [15:0] p1 = '0;
   logic [31:0] p4 = 32'hA5A5_A5A5;
   int          n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   assign rdata = sel ? rd4 : rd1;
   assign wt    = sel ? w4 : w1;
   qsys_test_gpi #(.WIDTH(16), .DEBOUNCE_DIV(1)) u_d1 (
      .csi_MCLK_clk        (clk),
      .rsi_MRST_reset_n    (rst_n),
      .avs_GPI_address     (addr),
      .avs_GPI_read        (rd & ~sel),
      .avs_GPI_readdata    (rd1),
      .avs_GPI_write       (wr & ~sel),
      .avs_GPI_writedata   (wdata),
      .avs_GPI_waitrequest (w1),
      .ins_GPI_irq         (q1),
      .coe_GPI             (p1)
   );
   qsys_test_gpi #(.WIDTH(32), .DEBOUNCE_DIV(4)) u_d4 (
      .csi_MCLK_clk        (clk),
      .rsi_MRST_reset_n    (rst_n),
      .avs_GPI_address     (addr),
      .avs_GPI_read        (rd & sel),
      .avs_GPI_readdata    (rd4),
      .avs_GPI_write       (wr & sel),
      .avs_GPI_writedata   (wdata),
      .avs_GPI_waitrequest (w4),
      .ins_GPI_irq         (q4),
      .coe_GPI             (p4)
   );
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, act, exp);
      end
   endtask
   task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
      @(negedge clk);
      addr = a;
      rd   = 1'b1;
      #1 chk({tag, "_wait1"}, 32'(wt), 32'd1);
      @(negedge clk);
      chk({tag, "_wait0"}, 32'(wt), 32'd0);
      chk(tag, rdata, exp);
      rd = 1'b0;
   endtask
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      wr    = 1'b1;
      #1 chk("wr_wait", 32'(wt), 32'd0);
      @(negedge clk);
      wr = 1'b0;
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_wait_d1", 32'(w1), 32'd1);
      chk("rst_wait_d4", 32'(w4), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_wait_d1", 32'(w1), 32'd0);
      chk("rel_wait_d4", 32'(w4), 32'd0);
      rd_chk(ADDR_DATA, 32'h0, "d1_rst_data");
      rd_chk(ADDR_EDGE, 32'h0, "d1_rst_edge");
      rd_chk(ADDR_MASK, 32'h0, "d1_rst_mask");
      rd_chk(ADDR_EDGE_SEL, 32'h0000_FFFF, "d1_rst_sel");
      sel = 1'b1;
      rd_chk(ADDR_DATA, 32'hA5A5_A5A5, "d4_prime_data");
      rd_chk(ADDR_EDGE, 32'h0, "d4_prime_edge");
      chk("d4_prime_irq", 32'(q4), 32'd0);
      sel = 1'b0;
      bus_write(ADDR_MASK, 32'h1);
      @(negedge clk);
      p1[0] = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk($sformatf("d1_irq_e%0d", i), 32'(q1), 32'd0);
      end
      @(negedge clk);
      chk("d1_irq_e4", 32'(q1), 32'd1);
      rd_chk(ADDR_DATA, 32'h1, "d1_data_b0");
      rd_chk(ADDR_EDGE, 32'h1, "d1_edge_b0");
      bus_write(ADDR_EDGE, 32'h1);
      chk("d1_irq_w1c", 32'(q1), 32'd0);
      rd_chk(ADDR_EDGE, 32'h0, "d1_edge_w1c");
      bus_write(ADDR_DATA, 32'hFFFF);
      rd_chk(ADDR_MASK, 32'h1, "d1_wr0_mask");
      rd_chk(ADDR_DATA, 32'h1, "d1_wr0_data");
      @(negedge clk);
      p1[1] = 1'b1;
      repeat (2) @(negedge clk);
      bus_write(ADDR_EDGE, 32'h2);
      rd_chk(ADDR_EDGE, 32'h2, "d1_set_wins");
      @(negedge clk);
      addr  = ADDR_MASK;
      rd    = 1'b1;
      wr    = 1'b1;
      wdata = 32'h3;
      @(negedge clk);
      wr = 1'b0;
      chk("d1_rw_wait0", 32'(wt), 32'd0);
      chk("d1_rw_old", rdata, 32'h1);
      rd = 1'b0;
      rd_chk(ADDR_MASK, 32'h3, "d1_rw_new");
      chk("d1_irq_mask", 32'(q1), 32'd1);
      sel = 1'b1;
      @(negedge clk);
      p4[3] = 1'b1;
      repeat (3) @(negedge clk);
      p4[3] = 1'b0;
      repeat (12) @(negedge clk);
      rd_chk(ADDR_DATA, 32'hA5A5_A5A5, "d4_short_data");
      rd_chk(ADDR_EDGE, 32'h0, "d4_short_edge");
      @(negedge clk);
      p4[3] = 1'b1;
      repeat (10) @(negedge clk);
      rd_chk(ADDR_DATA, 32'hA5A5_A5AD, "d4_long_data_hi");
      p4[3] = 1'b0;
      repeat (16) @(negedge clk);
      rd_chk(ADDR_DATA, 32'hA5A5_A5A5, "d4_long_data_lo");
      rd_chk(ADDR_EDGE, 32'h8, "d4_long_edge");
      bus_write(ADDR_EDGE, 32'h8);
      bus_write(ADDR_EDGE_SEL, 32'h0);
      bus_write(ADDR_MASK, 32'h20);
      @(negedge clk);
      p4[5] = 1'b0;
      repeat (16) @(negedge clk);
      chk("d4_fall_irq", 32'(q4), 32'd1);
      rd_chk(ADDR_EDGE, 32'h20, "d4_fall_edge");
      bus_write(ADDR_EDGE, 32'h20);
      chk("d4_fall_w1c_irq", 32'(q4), 32'd0);
      p4[5] = 1'b1;
      repeat (16) @(negedge clk);
      rd_chk(ADDR_EDGE, 32'h0, "d4_rise_ignored");
      chk("d4_rise_irq", 32'(q4), 32'd0);
      rd_chk(ADDR_DATA, 32'hA5A5_A5A5, "d4_rise_data");
      sel = 1'b0;
      @(negedge clk);
      addr = ADDR_MASK;
      rd   = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_wait", 32'(w1), 32'd1);
      chk("mid_rst_rdata", rd1, 32'h0);
      rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd_chk(ADDR_MASK, 32'h0, "post_rst_mask");
      rd_chk(ADDR_EDGE_SEL, 32'h0000_FFFF, "post_rst_sel");
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/qsys_test_gpi.md
# qsys_test_gpi

Avalon-MM slave that samples a 32-bit general-purpose input bus, synchronises and debounces it, latches per-bit edge events and raises a maskable interrupt. It is the input-side companion of the test GPO block: the GPO drives pins from a register, this block brings pins back into the register space. The block sits in the Qsys test subsystem on the MCU-facing Avalon bus.

## Interface
Parameters:
- WIDTH, 32, input bus width (1..32); readdata bits above WIDTH read 0.
- DEBOUNCE_DIV, 1000, clock cycles per debounce sample tick (>=1).

Ports:
- csi_MCLK_clk  in  1  system clock; single clock domain.
- rsi_MRST_reset_n  in  1  reset, asynchronous assert, active-low.
- avs_GPI_address  in  2  word address.
- avs_GPI_read  in  1  read strobe.
- avs_GPI_readdata  out  32  read data.
- avs_GPI_write  in  1  write strobe.
- avs_GPI_writedata  in  32  write data.
- avs_GPI_waitrequest  out  1  Avalon waitrequest.
- ins_GPI_irq  out  1  level interrupt, active-high.
- coe_GPI  in  WIDTH  asynchronous pin inputs.

## Operation
- Register map: 0 DATA (RO, debounced value); 1 EDGE (write-1-to-clear, latched events); 2 MASK (RW, irq enable per bit); 3 EDGE_SEL (RW, 1=capture rising, 0=capture falling).
- Reset values: DATA 0, EDGE 0, MASK 0, EDGE_SEL all ones, readdata 0, irq 0, waitrequest 1 while reset asserted.
- Sync: two-flop synchroniser on coe_GPI -> sync.
- Tick: prescaler counts 0..DEBOUNCE_DIV-1, tick on terminal count, wraps to 0; DIV=1 ticks every cycle.
- Debounce, on tick: per bit, if sync[i]==samp[i] then deb[i]<=sync[i]; samp<=sync. A bit must be stable across two consecutive ticks to change DATA.
- Prime: first tick after reset loads deb<=sync unconditionally and sets no edges.
- Edge capture: on the cycle deb[i] changes in the direction selected by EDGE_SEL[i], EDGE[i]<=1. Edge set and W1C of same bit in same cycle: set wins.
- irq = |(EDGE & MASK), combinational from registers.
- Writes to address 0 ignored; writes accepted in one cycle (waitrequest 0 for writes).
- Read FSM, states IDLE / ACK: IDLE + read -> waitrequest=1, readdata<=selected register, go ACK. ACK -> waitrequest=0 if read still high, return IDLE. Read dropped in ACK: return IDLE, no side effect. Reads have no side effects.
- Simultaneous read and write: write takes effect; read follows FSM and returns pre-write value.
- Reset mid-transaction: FSM -> IDLE, waitrequest 1, all registers to reset values, prescaler and prime flag cleared.

## Timing
- Read: 2 cycles per read, back-to-back reads each take 2 cycles; readdata valid in the cycle waitrequest is 0 and held until next read captures.
- Pin-to-DATA, DIV=1: pin stable before edge 1 -> DATA updated at edge 4. General: 2 sync cycles + up to 2*DIV cycles.
- EDGE set at same edge as DATA update; irq high combinationally after that edge.
- W1C write at edge k: EDGE bit 0 and irq low after edge k.
- waitrequest deasserts at the first clock edge after reset release.

## Structure
- Package qsys_test_gpi_pkg: address constants ADDR_DATA/EDGE/MASK/EDGE_SEL, read FSM state enum, EDGE_SEL reset constant.
- Sub-module qsys_test_gpi_debounce: synchroniser, prescaler, sample/deb registers, prime flag; outputs deb and a one-cycle deb_changed vector. Top level holds registers, edge logic, Avalon FSM.

## Test plan
- Reset, DIV=1: read all four addresses -> 0, 0, 0, 0x0000FFFF... for WIDTH=16 (EDGE_SEL all ones); each read exactly one waitrequest cycle.
- Pins held 0xA5A5A5A5 through reset release -> DATA 0xA5A5A5A5 after prime, EDGE 0, irq 0.
- MASK=0x1, pin0 0->1 -> DATA bit0 set at edge 4, EDGE=0x1, irq 1; write EDGE=0x1 -> EDGE 0, irq 0.
- DIV=4, pin3 pulse 3 cycles wide -> DATA and EDGE unchanged; 12-cycle pulse -> DATA bit3 toggles, EDGE bit3 set.
- EDGE_SEL=0, pin5 1->0 -> EDGE bit5 set; 0->1 -> no set. W1C coinciding with new edge -> bit stays 1.
- Reset asserted during read wait cycle -> waitrequest 1, readdata 0; after release, new read completes normally in 2 cycles.
